// File: rtl/simt_call_stack.sv
// Per-warp CALL/RET return-address stack with overflow/underflow fault reporting.
// Optional macro CALL_STACK_MASK_EN stores the active mask per entry and restores it on RET.
module simt_call_stack #(
  parameter int NUM_WARPS = 4,
  parameter int WARP_SIZE = 32,
  parameter int PC_WIDTH  = 32,
  parameter int DEPTH     = 8,
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_is_ret,
  input  logic [WW-1:0]        req_warp,
  input  logic [PC_WIDTH-1:0]  req_ret_pc,
  input  logic [WARP_SIZE-1:0] req_mask,
  input  logic [NUM_WARPS-1:0] warp_clr,
  output logic                 resp_valid,
  output logic [WW-1:0]        resp_warp,
  output logic [PC_WIDTH-1:0]  resp_pc,
  output logic [WARP_SIZE-1:0] resp_mask,
  output logic                 resp_fault,
  output logic                 resp_ovf,
  output logic                 resp_unf,
  input  logic [WW-1:0]        dbg_warp,
  output logic [DW-1:0]        dbg_depth
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]       depth_vec [NUM_WARPS];
  logic [PC_WIDTH-1:0] pc_mem    [NUM_WARPS][DEPTH];
`ifdef CALL_STACK_MASK_EN
  logic [WARP_SIZE-1:0] mask_mem [NUM_WARPS][DEPTH];
`endif

  logic [DW-1:0] cur_depth;
  logic          is_full, is_empty, clr_hit, is_call, is_ret, do_push, do_pop;
  logic [AW-1:0] wr_slot, rd_slot;

  logic                 resp_valid_q, resp_valid_d;
  logic [WW-1:0]        resp_warp_q, resp_warp_d;
  logic [PC_WIDTH-1:0]  resp_pc_q, resp_pc_d;
  logic [WARP_SIZE-1:0] resp_mask_q, resp_mask_d;
  logic                 resp_ovf_q, resp_ovf_d;
  logic                 resp_unf_q, resp_unf_d;

  always_comb begin
    cur_depth = depth_vec[req_warp];
    is_full   = (cur_depth == DW'(DEPTH));
    is_empty  = (cur_depth == '0);
    clr_hit   = warp_clr[req_warp];
    is_call   = req_valid && !req_is_ret;
    is_ret    = req_valid && req_is_ret;
    // A clear on the requesting warp suppresses the push/pop but not the response.
    do_push   = is_call && !is_full && !clr_hit;
    do_pop    = is_ret && !is_empty && !clr_hit;
    wr_slot   = cur_depth[AW-1:0];
    rd_slot   = wr_slot - AW'(1);
  end

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic [DW-1:0] depth_q, depth_d;
    logic          hit;

    always_comb begin
      hit     = (req_warp == WW'(gi));
      depth_d = depth_q;
      if (warp_clr[gi])
        depth_d = '0;
      else if (hit && do_push)
        depth_d = depth_q + DW'(1);
      else if (hit && do_pop)
        depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) depth_q <= '0;
      else     depth_q <= depth_d;
    end

    assign depth_vec[gi] = depth_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[req_warp][wr_slot] <= req_ret_pc;
`ifdef CALL_STACK_MASK_EN
      mask_mem[req_warp][wr_slot] <= req_mask;
`endif
    end
  end

  always_comb begin
    resp_valid_d = req_valid;
    resp_warp_d  = req_valid ? req_warp : '0;
    resp_ovf_d   = is_call && is_full;
    resp_unf_d   = is_ret && is_empty;
    resp_pc_d    = '0;
    resp_mask_d  = '0;
    if (is_ret && !is_empty) begin
      resp_pc_d = pc_mem[req_warp][rd_slot];
`ifdef CALL_STACK_MASK_EN
      resp_mask_d = mask_mem[req_warp][rd_slot];
`else
      resp_mask_d = req_mask;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_warp_q  <= '0;
      resp_pc_q    <= '0;
      resp_mask_q  <= '0;
      resp_ovf_q   <= 1'b0;
      resp_unf_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_warp_q  <= resp_warp_d;
      resp_pc_q    <= resp_pc_d;
      resp_mask_q  <= resp_mask_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_unf_q   <= resp_unf_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_warp  = resp_warp_q;
  assign resp_pc    = resp_pc_q;
  assign resp_mask  = resp_mask_q;
  assign resp_ovf   = resp_ovf_q;
  assign resp_unf   = resp_unf_q;
  assign resp_fault = resp_ovf_q | resp_unf_q;
  assign dbg_depth  = depth_vec[dbg_warp];

endmodule

// File: tb/tb_simt_call_stack.sv
// Randomized + directed bench for simt_call_stack against a queue-per-warp stack model.
// Honors CALL_STACK_MASK_EN the same way as the design.
module tb_simt_call_stack;

  localparam int NW    = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_is_ret;
  logic [1:0]  req_warp, dbg_warp, resp_warp;
  logic [31:0] req_ret_pc, req_mask, resp_pc, resp_mask;
  logic [3:0]  warp_clr, dbg_depth;
  logic        resp_valid, resp_fault, resp_ovf, resp_unf;

  int n_vec = 0;
  int n_err = 0;

  // Each warp stack holds {pc, mask}; top of stack is the back of the queue.
  logic [63:0] stk [NW][$];

  always #5 clk = ~clk;

  simt_call_stack dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_ret(req_is_ret), .req_warp(req_warp),
    .req_ret_pc(req_ret_pc), .req_mask(req_mask), .warp_clr(warp_clr),
    .resp_valid(resp_valid), .resp_warp(resp_warp), .resp_pc(resp_pc),
    .resp_mask(resp_mask), .resp_fault(resp_fault), .resp_ovf(resp_ovf),
    .resp_unf(resp_unf), .dbg_warp(dbg_warp), .dbg_depth(dbg_depth)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and check the response one cycle later.
  task automatic cyc(input bit v, input bit r, input int w, input logic [31:0] pc,
                     input logic [31:0] m, input logic [3:0] clr);
    logic [63:0] top;
    logic [31:0] e_pc, e_mask;
    bit          e_ovf, e_unf;
    int          dw;
    dw         = $urandom_range(0, NW-1);
    dbg_warp   = 2'(dw);
    req_valid  = v;
    req_is_ret = r;
    req_warp   = 2'(w);
    req_ret_pc = pc;
    req_mask   = m;
    warp_clr   = clr;
    #1;
    check("dbg_depth", 64'(dbg_depth), 64'(stk[dw].size()));
    e_pc = 0; e_mask = 0; e_ovf = 0; e_unf = 0;
    if (v && !r && stk[w].size() == DEPTH) e_ovf = 1;
    if (v && r) begin
      if (stk[w].size() == 0) e_unf = 1;
      else begin
        top  = stk[w][stk[w].size()-1];
        e_pc = top[63:32];
`ifdef CALL_STACK_MASK_EN
        e_mask = top[31:0];
`else
        e_mask = m;
`endif
      end
    end
    if (v && !clr[w]) begin
      if (!r && !e_ovf) stk[w].push_back({pc, m});
      if (r && !e_unf)  void'(stk[w].pop_back());
    end
    for (int i = 0; i < NW; i++) if (clr[i]) stk[i].delete();
    @(posedge clk);
    #1;
    check("resp_valid", 64'(resp_valid), 64'(v));
    if (v) check("resp_warp", 64'(resp_warp), 64'(w));
    check("resp_pc",    64'(resp_pc),    64'(e_pc));
    check("resp_mask",  64'(resp_mask),  64'(e_mask));
    check("resp_ovf",   64'(resp_ovf),   64'(e_ovf));
    check("resp_unf",   64'(resp_unf),   64'(e_unf));
    check("resp_fault", 64'(resp_fault), 64'(e_ovf | e_unf));
    req_valid = 0;
    warp_clr  = 0;
  endtask

  task automatic depth_of(input int w, input int exp, input string tag);
    dbg_warp = 2'(w);
    #1;
    check(tag, 64'(dbg_depth), 64'(exp));
  endtask

  initial begin
    int phase_call;
    rst = 1; req_valid = 0; req_is_ret = 0; req_warp = 0;
    req_ret_pc = 0; req_mask = 0; warp_clr = 0; dbg_warp = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(resp_valid), 64'(0));
    check("rst_fault", 64'(resp_fault), 64'(0));
    check("rst_pc",    64'(resp_pc),    64'(0));
    rst = 0;
    for (int w = 0; w < NW; w++) depth_of(w, 0, "rst_depth");

    // Single call / nested calls
    cyc(1, 0, 0, 32'd2, 32'hFFFF_FFFF, 4'h0);
    depth_of(0, 1, "t1_depth1");
    cyc(1, 1, 0, 32'd0, 32'hFFFF_FFFF, 4'h0);
    check("t1_pc", 64'(resp_pc), 64'd2);
    depth_of(0, 0, "t1_depth0");
    cyc(1, 0, 0, 32'd2, 32'h1, 4'h0);
    cyc(1, 0, 0, 32'd5, 32'h2, 4'h0);
    cyc(1, 1, 0, 32'd0, 32'h3, 4'h0);
    check("t2_pc5", 64'(resp_pc), 64'd5);
    cyc(1, 1, 0, 32'd0, 32'h3, 4'h0);
    check("t2_pc2", 64'(resp_pc), 64'd2);

    // Overflow on w1, then underflow on w2
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 32'(10 + i), 32'(i), 4'h0);
    cyc(1, 0, 1, 32'd99, 32'h0, 4'h0);
    check("t3_ovf", 64'(resp_ovf), 64'd1);
    depth_of(1, 8, "t3_depth");
    cyc(1, 1, 1, 32'd0, 32'h0, 4'h0);
    check("t3_pc17", 64'(resp_pc), 64'd17);
    cyc(1, 1, 2, 32'd0, 32'h0, 4'h0);
    check("t4_unf", 64'(resp_unf), 64'd1);

    // Clear collides with RET on the same warp
    cyc(1, 0, 0, 32'd20, 32'h0, 4'h0);
    cyc(1, 0, 0, 32'd21, 32'h0, 4'h0);
    cyc(1, 1, 0, 32'd0, 32'h0, 4'h1);
    check("t5_pc", 64'(resp_pc), 64'd21);
    depth_of(0, 0, "t5_depth");
    cyc(1, 1, 0, 32'd0, 32'h0, 4'h0);
    check("t5_unf", 64'(resp_unf), 64'd1);

    // Isolation + mask restore
    cyc(1, 0, 0, 32'd3, 32'h0000_FFFF, 4'h0);
    cyc(1, 0, 3, 32'd7, 32'h1234_5678, 4'h0);
    cyc(1, 1, 0, 32'd0, 32'hFFFF_FFFF, 4'h0);
`ifdef CALL_STACK_MASK_EN
    check("t6_mask", 64'(resp_mask), 64'h0000_FFFF);
`else
    check("t6_mask", 64'(resp_mask), 64'hFFFF_FFFF);
`endif
    depth_of(3, 1, "t6_w3depth");

    // Random traffic alternating call-heavy and ret-heavy phases
    phase_call = 1;
    for (int n = 0; n < 600; n++) begin
      bit          v, r;
      logic [3:0]  clr;
      if (n % 60 == 0) phase_call = !phase_call;
      v   = ($urandom_range(0, 9) != 0);
      r   = phase_call ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
      cyc(v, r, $urandom_range(0, NW-1), $urandom, $urandom, clr);
    end

    // Reset with a request in flight: response dropped, depths cleared
    for (int i = 0; i < 3; i++) cyc(1, 0, 2, 32'(40 + i), 32'h0, 4'h0);
    req_valid = 1; req_is_ret = 1; req_warp = 2'd2; rst = 1;
    @(posedge clk);
    #1;
    check("midrst_valid", 64'(resp_valid), 64'd0);
    rst = 0; req_valid = 0;
    for (int w = 0; w < NW; w++) stk[w].delete();
    depth_of(2, 0, "midrst_depth");
    cyc(1, 1, 2, 32'd0, 32'h0, 4'h0);
    check("midrst_unf", 64'(resp_unf), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
